pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised program-counter generator for the in-order RISC-V core, feeding the instruction-fetch stage. It computes and holds the fetch address. It advances sequentially under a valid/ready handshake and accepts prioritised redirects from the execute stage (branch, JAL, JALR) and the trap unit (trap entry, MRET). Unlike the fixed-offset PC it replaces, targets are computed from an explicit source PC, so pipeline depth no longer leaks into offset arithmetic.

## Interface
- XLEN, 32, address width (≥16)
- RESET_VEC, 0, PC value loaded on reset
- JAL_W, 21, width of JAL offset (two's complement)
- BR_W, 13, width of branch offset (two's complement)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- pc_addr  out  XLEN  current fetch address
- pc_valid  out  1  pc_addr is a valid fetch request
- pc_ready  in  1  fetch stage accepts pc_addr this cycle
- stall  in  1  pipeline stall; freezes sequential advance
- halt  in  1  enter HALT after current cycle (WFI/debug)
- resume  in  1  leave HALT
- br_take  in  1  branch taken, target = src_pc + sext(br_ofs)
- jal_take  in  1  JAL, target = src_pc + sext(jal_ofs)
- jalr_take  in  1  JALR, target = jalr_tgt & ~1
- src_pc  in  XLEN  PC of the redirecting instruction
- br_ofs  in  BR_W  branch offset
- jal_ofs  in  JAL_W  JAL offset
- jalr_tgt  in  XLEN  rs1+imm from ALU
- trap_take  in  1  trap entry, target = trap_vec
- trap_vec  in  XLEN  mtvec-derived address
- mret_take  in  1  return, target = epc
- epc  in  XLEN  mepc
- flush  out  1  one-cycle pulse: redirect accepted, younger fetches must be killed
- misalign_exc  out  1  see Configuration

## Operation
- States: BOOT, RUN, HALT.
- BOOT (entered on reset): pc_addr=RESET_VEC, pc_valid=0, flush=0, misalign_exc=0. The next cycle goes to RUN unconditionally.
- RUN: pc_valid=1.
  - Fire = pc_valid & pc_ready & !stall. On fire, pc_addr += 4.
  - Otherwise pc_addr holds; the request stays stable until accepted.
- Redirect priority: trap_take > mret_take > br_take > jal_take > jalr_take.
  - The highest-priority asserted redirect wins and the rest are ignored.
  - Redirects apply regardless of stall and pc_ready.
  - A redirect loads pc_addr with its target next cycle and pulses flush.
- Arithmetic: offsets are sign-extended to XLEN. All sums wrap modulo 2^XLEN with no overflow flag. The JALR target has bit 0 cleared.
- halt in RUN: the state moves to HALT and pc_addr holds. HALT: pc_valid=0.
  - resume returns to RUN with the same pc_addr.
  - A redirect in HALT updates pc_addr and pulses flush, but the state stays HALT.
  - trap_take in HALT also sets the state to RUN (interrupt wake).
- Simultaneous halt and redirect in RUN: the redirect is applied and the state goes to HALT.

## Timing
- Every state and output update happens on the rising edge of clk. There are no combinational input-to-output paths except pc_valid, which decodes the state.
- Redirect latency is 1 cycle: redirect at edge N means pc_addr=target and flush=1 during cycle N+1.
- Sequential latency is 1 cycle after fire.
- After rst deasserts, the first valid fetch is one cycle later (BOOT lasts 1 cycle).
- rst low mid-operation dominates everything: the state returns to BOOT and pc_addr=RESET_VEC at the next edge.

## Configuration
- PC_MISALIGN_CHK_EN defined:
  - A selected redirect target with bits[1:0]≠0 is not applied and pc_addr holds.
  - misalign_exc pulses for 1 cycle and flush is not asserted.
  - Trap and MRET targets are exempt from the check.
- Not defined: targets are applied unchecked and misalign_exc is tied 0.

## Test plan
- Reset to steady run: rst=0 for 2 cycles, then 1. Required: pc_valid=0, pc_addr=0x0 for one cycle, then pc_valid=1 with pc_addr 0x0, 0x4, 0x8 while pc_ready=1.
- Backpressure: pc_ready=0 for 3 cycles at pc=0x10. Required: pc_addr holds 0x10; the next address after release is 0x14. stall=1 gives the same behaviour.
- Offset arithmetic:
  - Branch src_pc=0x100, br_ofs=-8 (0x1FF8) → pc_addr=0xF8 and flush=1 one cycle later.
  - JAL src_pc=0x0, jal_ofs=-4 → 0xFFFFFFFC (wrap).
- Priority: trap_take (vec 0x80) and br_take together → 0x80. Same test with mret_take (epc 0x200) and jalr_take together → 0x200. JALR tgt 0x301 → 0x300.
- Halt/resume: halt at pc=0x40 → pc_valid=0 and pc_addr=0x40 until resume, then fetch 0x40. trap_take in HALT → RUN at trap_vec.
- With PC_MISALIGN_CHK_EN: br target 0x102 → misalign_exc=1, flush=0, pc_addr unchanged. Without the macro: pc_addr=0x102.

Source files
------------

// File: rtl/pc_gen.sv
// ---------------------------------------------------------------------------
// pc_gen -- program-counter generator for the in-order RISC-V core.
//
// Holds the instruction-fetch address. The address advances by 4 on each
// accepted fetch and can be redirected by execute (branch/JAL/JALR) or by the
// trap unit (trap entry/MRET). Redirect targets are computed from an explicit
// source PC, so pipeline depth does not affect the offset arithmetic.
//
// Optional feature (compile-time macro): PC_MISALIGN_CHK_EN
//   When defined, a branch, JAL or JALR target with bits[1:0] != 0 is not
//   applied. misalign_exc pulses instead of flush. Trap and MRET targets are
//   exempt. When undefined, targets are applied unchecked and misalign_exc
//   is tied to 0.
//
// Ports:
//   clk, rst         clock; synchronous active-low reset
//   pc_addr          current fetch address (registered)
//   pc_valid         pc_addr is a valid fetch request (decoded from state)
//   pc_ready         fetch stage accepts pc_addr this cycle
//   stall            freezes sequential advance
//   halt / resume    enter / leave the HALT state
//   br_take, br_ofs  taken branch, target = src_pc + sext(br_ofs)
//   jal_take, jal_ofs JAL, target = src_pc + sext(jal_ofs)
//   jalr_take, jalr_tgt JALR, target = jalr_tgt with bit 0 cleared
//   src_pc           PC of the redirecting instruction
//   trap_take, trap_vec trap entry, target = trap_vec
//   mret_take, epc   return from trap, target = epc
//   flush            one-cycle pulse: a redirect was applied
//   misalign_exc     one-cycle pulse: a redirect target was misaligned
// ---------------------------------------------------------------------------
module pc_gen #(
   parameter int                XLEN      = 32,
   parameter logic [XLEN-1:0]   RESET_VEC = '0,
   parameter int                JAL_W     = 21,
   parameter int                BR_W      = 13
) (
   input  logic              clk,
   input  logic              rst,
   output logic [XLEN-1:0]   pc_addr,
   output logic              pc_valid,
   input  logic              pc_ready,
   input  logic              stall,
   input  logic              halt,
   input  logic              resume,
   input  logic              br_take,
   input  logic              jal_take,
   input  logic              jalr_take,
   input  logic [XLEN-1:0]   src_pc,
   input  logic [BR_W-1:0]   br_ofs,
   input  logic [JAL_W-1:0]  jal_ofs,
   input  logic [XLEN-1:0]   jalr_tgt,
   input  logic              trap_take,
   input  logic [XLEN-1:0]   trap_vec,
   input  logic              mret_take,
   input  logic [XLEN-1:0]   epc,
   output logic              flush,
   output logic              misalign_exc
);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   state_t            state, state_next;
   logic [XLEN-1:0]   pc_next;
   logic              flush_next;
   logic              fire;

   logic              redir_sel;   // some redirect is asserted
   logic [XLEN-1:0]   redir_tgt;   // target of the winning redirect
   logic              redir_bad;   // winning target rejected as misaligned

   // Sign-extended offsets; sums wrap modulo 2^XLEN.
   logic [XLEN-1:0]   br_sext, jal_sext;
   assign br_sext  = {{(XLEN-BR_W){br_ofs[BR_W-1]}}, br_ofs};
   assign jal_sext = {{(XLEN-JAL_W){jal_ofs[JAL_W-1]}}, jal_ofs};

   // ------------------------------------------------------------------------
   // Redirect selection: trap > mret > branch > jal > jalr.
   // ------------------------------------------------------------------------
`ifdef PC_MISALIGN_CHK_EN
   logic redir_chk;   // winning redirect is subject to the alignment check
`endif

   always_comb begin
      // NOTE: every signal written in a combinational block gets a default
      // first; a path that leaves one unassigned would infer a latch.
      redir_sel = 1'b1;
      redir_tgt = pc_addr;
`ifdef PC_MISALIGN_CHK_EN
      redir_chk = 1'b1;
`endif
      if (trap_take) begin
         redir_tgt = trap_vec;
`ifdef PC_MISALIGN_CHK_EN
         redir_chk = 1'b0;
`endif
      end else if (mret_take) begin
         redir_tgt = epc;
`ifdef PC_MISALIGN_CHK_EN
         redir_chk = 1'b0;
`endif
      end else if (br_take) begin
         redir_tgt = src_pc + br_sext;
      end else if (jal_take) begin
         redir_tgt = src_pc + jal_sext;
      end else if (jalr_take) begin
         redir_tgt = jalr_tgt & ~{{(XLEN-1){1'b0}}, 1'b1};
      end else begin
         redir_sel = 1'b0;
      end
   end

`ifdef PC_MISALIGN_CHK_EN
   assign redir_bad = redir_sel & redir_chk & (|redir_tgt[1:0]);
`else
   assign redir_bad = 1'b0;
`endif

   assign fire = pc_valid & pc_ready & ~stall;

   // ------------------------------------------------------------------------
   // State and datapath registers.
   // ------------------------------------------------------------------------
`ifdef PC_MISALIGN_CHK_EN
   logic misalign_next;
`endif

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      if (!rst) begin
         state   <= BOOT;
         pc_addr <= RESET_VEC;
         flush   <= 1'b0;
`ifdef PC_MISALIGN_CHK_EN
         misalign_exc <= 1'b0;
`endif
      end else begin
         state   <= state_next;
         pc_addr <= pc_next;
         flush   <= flush_next;
`ifdef PC_MISALIGN_CHK_EN
         misalign_exc <= misalign_next;
`endif
      end
   end

`ifndef PC_MISALIGN_CHK_EN
   assign misalign_exc = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Next-state / next-PC logic.
   // ------------------------------------------------------------------------
   always_comb begin
      state_next = state;
      pc_next    = pc_addr;
      flush_next = 1'b0;
`ifdef PC_MISALIGN_CHK_EN
      misalign_next = 1'b0;
`endif
      unique case (state)
         BOOT: begin
            // Redirects are not yet meaningful; just start fetching.
            state_next = RUN;
         end
         RUN: begin
            if (redir_sel) begin
               if (redir_bad) begin
`ifdef PC_MISALIGN_CHK_EN
                  misalign_next = 1'b1;
`endif
               end else begin
                  pc_next    = redir_tgt;
                  flush_next = 1'b1;
               end
            end else if (fire && !halt) begin
               // A halting cycle keeps the current address so that it is
               // re-fetched after resume.
               pc_next = pc_addr + XLEN'(4);
            end
            if (halt) state_next = HALT;
         end
         HALT: begin
            if (redir_sel) begin
               if (redir_bad) begin
`ifdef PC_MISALIGN_CHK_EN
                  misalign_next = 1'b1;
`endif
               end else begin
                  pc_next    = redir_tgt;
                  flush_next = 1'b1;
               end
            end
            // trap_take is also an interrupt wake-up.
            if (resume || trap_take) state_next = RUN;
         end
         default: state_next = BOOT;
      endcase
   end

   // ------------------------------------------------------------------------
   // Output decode.
   // ------------------------------------------------------------------------
   always_comb begin
      pc_valid = (state == RUN);
   end

endmodule

// File: tb/tb_pc_gen.sv
// ---------------------------------------------------------------------------
// tb_pc_gen -- directed testbench for pc_gen (default parameters).
// Expected values are hand-computed constants. Outputs are sampled 1 ns after
// each rising edge; inputs are changed at that same point.
// ---------------------------------------------------------------------------
module tb_pc_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_addr;
   logic        pc_valid;
   logic        pc_ready;
   logic        stall;
   logic        halt;
   logic        resume;
   logic        br_take;
   logic        jal_take;
   logic        jalr_take;
   logic [31:0] src_pc;
   logic [12:0] br_ofs;
   logic [20:0] jal_ofs;
   logic [31:0] jalr_tgt;
   logic        trap_take;
   logic [31:0] trap_vec;
   logic        mret_take;
   logic [31:0] epc;
   logic        flush;
   logic        misalign_exc;

   int n_assert = 0;
   int n_fail   = 0;

   pc_gen dut (
      .clk          (clk),
      .rst          (rst),
      .pc_addr      (pc_addr),
      .pc_valid     (pc_valid),
      .pc_ready     (pc_ready),
      .stall        (stall),
      .halt         (halt),
      .resume       (resume),
      .br_take      (br_take),
      .jal_take     (jal_take),
      .jalr_take    (jalr_take),
      .src_pc       (src_pc),
      .br_ofs       (br_ofs),
      .jal_ofs      (jal_ofs),
      .jalr_tgt     (jalr_tgt),
      .trap_take    (trap_take),
      .trap_vec     (trap_vec),
      .mret_take    (mret_take),
      .epc          (epc),
      .flush        (flush),
      .misalign_exc (misalign_exc)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic [31:0] exp_pc,
                            input logic exp_valid, input logic exp_flush);
      check({tag, ".pc"},    pc_addr,          exp_pc);
      check({tag, ".valid"}, 32'(pc_valid),    32'(exp_valid));
      check({tag, ".flush"}, 32'(flush),       32'(exp_flush));
      check({tag, ".mis"},   32'(misalign_exc), 32'(1'b0));
   endtask

   task automatic clear_redirects();
      br_take   = 1'b0;
      jal_take  = 1'b0;
      jalr_take = 1'b0;
      trap_take = 1'b0;
      mret_take = 1'b0;
   endtask

   initial begin
      rst      = 1'b0;
      pc_ready = 1'b1;
      stall    = 1'b0;
      halt     = 1'b0;
      resume   = 1'b0;
      src_pc   = '0;
      br_ofs   = '0;
      jal_ofs  = '0;
      jalr_tgt = '0;
      trap_vec = '0;
      epc      = '0;
      clear_redirects();

      // Reset held for two edges, then BOOT for one cycle.
      tick();
      tick();
      check_out("reset", 32'h0, 1'b0, 1'b0);
      rst = 1'b1;
      tick();
      check_out("run0", 32'h0, 1'b1, 1'b0);
      tick();
      check_out("run4", 32'h4, 1'b1, 1'b0);
      tick();
      check_out("run8", 32'h8, 1'b1, 1'b0);
      tick();
      tick();
      check("reach10", pc_addr, 32'h10);

      // Backpressure via pc_ready, then via stall.
      pc_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("ready_hold", pc_addr, 32'h10);
      end
      pc_ready = 1'b1;
      tick();
      check("ready_rel", pc_addr, 32'h14);
      stall = 1'b1;
      tick();
      tick();
      check("stall_hold", pc_addr, 32'h14);
      stall = 1'b0;
      tick();
      check("stall_rel", pc_addr, 32'h18);

      // Branch with negative offset.
      br_take = 1'b1; src_pc = 32'h100; br_ofs = 13'h1FF8;
      tick();
      check_out("br_neg", 32'hF8, 1'b1, 1'b1);
      clear_redirects();
      tick();
      check_out("br_after", 32'hFC, 1'b1, 1'b0);

      // JAL wrapping below zero.
      jal_take = 1'b1; src_pc = 32'h0; jal_ofs = 21'h1FFFFC;
      tick();
      check_out("jal_wrap", 32'hFFFF_FFFC, 1'b1, 1'b1);
      clear_redirects();
      tick();
      check("seq_wrap", pc_addr, 32'h0);

      // Priority.
      trap_take = 1'b1; trap_vec = 32'h80;
      br_take = 1'b1; src_pc = 32'h100; br_ofs = 13'h1FF8;
      tick();
      check_out("trap_over_br", 32'h80, 1'b1, 1'b1);
      clear_redirects();
      mret_take = 1'b1; epc = 32'h200;
      jalr_take = 1'b1; jalr_tgt = 32'h500;
      tick();
      check_out("mret_over_jalr", 32'h200, 1'b1, 1'b1);
      clear_redirects();
      jalr_take = 1'b1; jalr_tgt = 32'h301;
      tick();
      check_out("jalr_lsb", 32'h300, 1'b1, 1'b1);
      clear_redirects();
      tick();
      check_out("jalr_after", 32'h304, 1'b1, 1'b0);

      // Halt / resume at 0x40.
      jalr_take = 1'b1; jalr_tgt = 32'h40;
      tick();
      clear_redirects();
      halt = 1'b1;
      tick();
      check_out("halt_enter", 32'h40, 1'b0, 1'b0);
      halt = 1'b0;
      tick();
      check_out("halt_stay", 32'h40, 1'b0, 1'b0);
      resume = 1'b1;
      tick();
      check_out("resume", 32'h40, 1'b1, 1'b0);
      resume = 1'b0;
      pc_ready = 1'b0;
      tick();
      check_out("resume_fetch", 32'h40, 1'b1, 1'b0);

      // Redirect while halted, then trap wake-up.
      halt = 1'b1;
      tick();
      halt = 1'b0;
      br_take = 1'b1; src_pc = 32'h100; br_ofs = 13'h0020;
      tick();
      check_out("halt_br", 32'h120, 1'b0, 1'b1);
      clear_redirects();
      trap_take = 1'b1; trap_vec = 32'h80;
      tick();
      check_out("halt_trap", 32'h80, 1'b1, 1'b1);
      clear_redirects();
      pc_ready = 1'b1;

      // Halt and redirect together in RUN.
      halt = 1'b1;
      jal_take = 1'b1; src_pc = 32'h1000; jal_ofs = 21'h8;
      tick();
      check_out("halt_jal", 32'h1008, 1'b0, 1'b1);
      halt = 1'b0;
      clear_redirects();
      resume = 1'b1;
      tick();
      check_out("halt_jal_res", 32'h1008, 1'b1, 1'b0);
      resume = 1'b0;

      // Misaligned branch target 0x102 while pc is 0x1008 (pc_ready=1).
      br_take = 1'b1; src_pc = 32'h100; br_ofs = 13'h0002;
      tick();
`ifdef PC_MISALIGN_CHK_EN
      check("mis.pc",    pc_addr,            32'h1008);
      check("mis.flush", 32'(flush),         32'(1'b0));
      check("mis.exc",   32'(misalign_exc),  32'(1'b1));
`else
      check("mis.pc",    pc_addr,            32'h102);
      check("mis.flush", 32'(flush),         32'(1'b1));
      check("mis.exc",   32'(misalign_exc),  32'(1'b0));
`endif
      clear_redirects();
      tick();
`ifdef PC_MISALIGN_CHK_EN
      check_out("mis_after", 32'h100C, 1'b1, 1'b0);
`else
      check_out("mis_after", 32'h106, 1'b1, 1'b0);
`endif

      // Reset mid-operation.
      rst = 1'b0;
      tick();
      check_out("mid_reset", 32'h0, 1'b0, 1'b0);
      rst = 1'b1;
      tick();
      check_out("mid_boot", 32'h0, 1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
